// File: rtl/tx_huge_pages_cpl_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_huge_pages_cpl_if
// Purpose  : TRN receive/transmit bus plus TX ownership handshake.
// Revision : 1.0
// ============================================================================
interface tx_huge_pages_cpl_if;
    logic [63:0] trn_rd;
    logic [7:0]  trn_rrem_n;
    logic        trn_rsof_n;
    logic        trn_reof_n;
    logic        trn_rsrc_rdy_n;
    logic        trn_rdst_rdy_n;
    logic [6:0]  trn_rbar_hit_n;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n;
    logic        tx_req;
    logic        tx_gnt;
    logic        tx_done;

    modport master (
        input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
               trn_rdst_rdy_n, trn_rbar_hit_n, trn_tdst_rdy_n, tx_gnt,
        output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
               trn_tsrc_dsc_n, tx_req, tx_done
    );

    modport slave (
        output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
               trn_rdst_rdy_n, trn_rbar_hit_n, trn_tdst_rdy_n, tx_gnt,
        input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
               trn_tsrc_dsc_n, tx_req, tx_done
    );
endinterface
`default_nettype wire

// File: rtl/tx_huge_pages_cpl.sv
`default_nettype none
// ============================================================================
// Module   : tx_huge_pages_cpl
// Purpose  : Completer for host reads of the BAR2 huge-page control window.
// Revision : 1.0
// ============================================================================
module tx_huge_pages_cpl #(
    parameter int BAR_IDX       = 2,
    parameter int REQ_FIFO_LOG2 = 2
) (
    input  wire logic               trn_clk,
    input  wire logic               reset,
    tx_huge_pages_cpl_if.master     trn,
    input  wire logic [15:0]        cfg_completer_id,
    input  wire logic [63:0]        huge_page_addr_1,
    input  wire logic [63:0]        huge_page_addr_2,
    input  wire logic               huge_page_status_1,
    input  wire logic               huge_page_status_2,
    output logic                    req_overflow
);

    localparam logic [6:0] MEM_RD32 = 7'b000_0000;
    localparam logic [6:0] MEM_RD64 = 7'b010_0000;
    localparam logic [6:0] FT_CPLD  = 7'b100_1010;
    localparam logic [6:0] FT_CPL   = 7'b000_1010;
    localparam logic [REQ_FIFO_LOG2:0] FIFO_DEPTH = {1'b1, {REQ_FIFO_LOG2{1'b0}}};

    typedef struct packed {
        logic [5:0]  dw_idx;
        logic        is64;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic        ur;
        logic [15:0] req_id;
        logic [7:0]  tag;
    } req_t;

    typedef enum logic [0:0] {R_IDLE, R_ADDR} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_REQ, T_BEAT0, T_BEAT1, T_DONE} tx_state_t;

    rx_state_t rx_state, rx_state_nxt;
    req_t      hdr, hdr_nxt, push_entry, head;
    logic      hdr_load, push_req, do_push, do_pop, fifo_full, fifo_empty, rx_valid;
    logic [6:0] rx_ft;

    logic [REQ_FIFO_LOG2:0]   count;
    logic [REQ_FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    req_t fifo_mem [0:(1<<REQ_FIFO_LOG2)-1];

    assign rx_valid = !trn.trn_rsrc_rdy_n && !trn.trn_rdst_rdy_n;
    assign rx_ft    = trn.trn_rd[62:56];

    // ------------------------------------------------------------------ RX
    always_comb begin
        rx_state_nxt = rx_state;
        hdr_load     = 1'b0;
        push_req     = 1'b0;
        push_entry   = hdr;
        hdr_nxt      = hdr;
        hdr_nxt.dw_idx = 6'd0;
        hdr_nxt.is64   = (rx_ft == MEM_RD64);
        hdr_nxt.tc     = trn.trn_rd[54:52];
        hdr_nxt.attr   = trn.trn_rd[45:44];
        hdr_nxt.ur     = (trn.trn_rd[41:32] != 10'd1);
        hdr_nxt.req_id = trn.trn_rd[31:16];
        hdr_nxt.tag    = trn.trn_rd[15:8];
        case (rx_state)
            R_IDLE: begin
                if (rx_valid && !trn.trn_rsof_n && !trn.trn_rbar_hit_n[BAR_IDX] &&
                    (rx_ft == MEM_RD32 || rx_ft == MEM_RD64)) begin
                    hdr_load     = 1'b1;
                    rx_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                if (rx_valid) begin
                    push_req          = 1'b1;
                    push_entry.dw_idx = hdr.is64 ? trn.trn_rd[7:2] : trn.trn_rd[39:34];
                    rx_state_nxt      = R_IDLE;
                end
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            rx_state <= R_IDLE;
            hdr      <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            if (hdr_load) begin
                hdr <= hdr_nxt;
            end
        end
    end

    // ---------------------------------------------------------------- FIFO
    assign fifo_full  = (count == FIFO_DEPTH);
    assign fifo_empty = (count == '0);
    assign do_push    = push_req && !fifo_full;
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            req_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && fifo_full) req_overflow <= 1'b1;
        end
    end

    always_ff @(posedge trn_clk) begin
        if (do_push) fifo_mem[wr_ptr] <= push_entry;
    end

    // ------------------------------------------------------------ read map
    logic [31:0] rd_value, payload, dw0, dw1, dw2;

    always_comb begin
        rd_value = 32'h0;
        case (head.dw_idx)
            6'b010000: rd_value = huge_page_addr_1[31:0];
            6'b010001: rd_value = huge_page_addr_1[63:32];
            6'b010010: rd_value = huge_page_addr_2[31:0];
            6'b010011: rd_value = huge_page_addr_2[63:32];
            6'b011000: rd_value = {31'b0, huge_page_status_1};
            6'b011001: rd_value = {31'b0, huge_page_status_2};
            default:   rd_value = 32'h0;
        endcase
    end

    assign payload = head.ur ? 32'h0 : {rd_value[7:0], rd_value[15:8], rd_value[23:16], rd_value[31:24]};
    assign dw0 = {1'b0, (head.ur ? FT_CPL : FT_CPLD), 1'b0, head.tc, 4'b0, 1'b0, 1'b0,
                  head.attr, 2'b0, (head.ur ? 10'd0 : 10'd1)};
    assign dw1 = {cfg_completer_id, (head.ur ? 3'b001 : 3'b000), 1'b0, 12'd4};
    assign dw2 = {head.req_id, head.tag, 1'b0, head.dw_idx[4:0], 2'b00};

    // ------------------------------------------------------------------ TX
    tx_state_t   tx_state, tx_state_nxt;
    logic [63:0] td, td_nxt, beat1, beat1_nxt;
    logic [7:0]  trem_n, trem_n_nxt, beat1_rem, beat1_rem_nxt;
    logic        tsof_n, tsof_n_nxt, teof_n, teof_n_nxt, tsrc_n, tsrc_n_nxt;
    logic        req, req_nxt, done, done_nxt;

    always_comb begin
        tx_state_nxt  = tx_state;
        td_nxt        = td;
        trem_n_nxt    = trem_n;
        tsof_n_nxt    = tsof_n;
        teof_n_nxt    = teof_n;
        tsrc_n_nxt    = tsrc_n;
        beat1_nxt     = beat1;
        beat1_rem_nxt = beat1_rem;
        req_nxt       = req;
        done_nxt      = 1'b0;
        do_pop        = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (!fifo_empty) begin
                    req_nxt      = 1'b1;
                    tx_state_nxt = T_REQ;
                end
            end
            T_REQ: begin
                // Both beats are frozen here so the payload reflects this cycle.
                if (trn.tx_gnt) begin
                    td_nxt        = {dw0, dw1};
                    trem_n_nxt    = 8'h00;
                    tsof_n_nxt    = 1'b0;
                    teof_n_nxt    = 1'b1;
                    tsrc_n_nxt    = 1'b0;
                    beat1_nxt     = {dw2, payload};
                    beat1_rem_nxt = head.ur ? 8'h0F : 8'h00;
                    tx_state_nxt  = T_BEAT0;
                end
            end
            T_BEAT0: begin
                if (!trn.trn_tdst_rdy_n) begin
                    td_nxt       = beat1;
                    trem_n_nxt   = beat1_rem;
                    tsof_n_nxt   = 1'b1;
                    teof_n_nxt   = 1'b0;
                    tx_state_nxt = T_BEAT1;
                end
            end
            T_BEAT1: begin
                if (!trn.trn_tdst_rdy_n) begin
                    do_pop       = 1'b1;
                    done_nxt     = 1'b1;
                    req_nxt      = 1'b0;
                    tsrc_n_nxt   = 1'b1;
                    teof_n_nxt   = 1'b1;
                    tx_state_nxt = T_DONE;
                end
            end
            T_DONE:  tx_state_nxt = T_IDLE;
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            tx_state  <= T_IDLE;
            td        <= 64'h0;
            trem_n    <= 8'hFF;
            tsof_n    <= 1'b1;
            teof_n    <= 1'b1;
            tsrc_n    <= 1'b1;
            beat1     <= 64'h0;
            beat1_rem <= 8'hFF;
            req       <= 1'b0;
            done      <= 1'b0;
        end else begin
            tx_state  <= tx_state_nxt;
            td        <= td_nxt;
            trem_n    <= trem_n_nxt;
            tsof_n    <= tsof_n_nxt;
            teof_n    <= teof_n_nxt;
            tsrc_n    <= tsrc_n_nxt;
            beat1     <= beat1_nxt;
            beat1_rem <= beat1_rem_nxt;
            req       <= req_nxt;
            done      <= done_nxt;
        end
    end

    assign trn.trn_td         = td;
    assign trn.trn_trem_n     = trem_n;
    assign trn.trn_tsof_n     = tsof_n;
    assign trn.trn_teof_n     = teof_n;
    assign trn.trn_tsrc_rdy_n = tsrc_n;
    assign trn.trn_tsrc_dsc_n = 1'b1;
    assign trn.tx_req         = req;
    assign trn.tx_done        = done;

    logic unused_sink;
    assign unused_sink = ^{trn.trn_rrem_n, trn.trn_reof_n, trn.trn_rd, trn.trn_rbar_hit_n, head.is64};

endmodule
`default_nettype wire

// File: tb/tb_tx_huge_pages_cpl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_huge_pages_cpl
// Purpose  : Directed, table-driven self-checking bench for tx_huge_pages_cpl.
// Revision : 1.0
// ============================================================================
module tb_tx_huge_pages_cpl;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] cpl_id;
    logic [63:0] hpa1, hpa2;
    logic        st1, st2;
    logic        overflow;

    tx_huge_pages_cpl_if bus();

    tx_huge_pages_cpl #(.BAR_IDX(2), .REQ_FIFO_LOG2(2)) dut (
        .trn_clk            (clk),
        .reset              (rst),
        .trn                (bus),
        .cfg_completer_id   (cpl_id),
        .huge_page_addr_1   (hpa1),
        .huge_page_addr_2   (hpa2),
        .huge_page_status_1 (st1),
        .huge_page_status_2 (st2),
        .req_overflow       (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        is64;
        logic [63:0] addr;
        logic [9:0]  len;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [31:0] dw0, dw1, dw2, dw3;
        logic [7:0]  rem1;
    } vec_t;

    vec_t vecs [9];

    task automatic rx_idle();
        bus.trn_rsrc_rdy_n = 1'b1;
        bus.trn_rsof_n     = 1'b1;
        bus.trn_reof_n     = 1'b1;
        bus.trn_rd         = 64'h0;
        bus.trn_rrem_n     = 8'h00;
        bus.trn_rbar_hit_n = 7'h7F;
    endtask

    // Two-beat request; leaves the bus idle one edge after the last beat.
    task automatic send_tlp(input logic [6:0] ft, input logic [6:0] bar_n, input logic [2:0] tc,
                            input logic [1:0] attr, input logic [9:0] len, input logic [15:0] rid,
                            input logic [7:0] tag, input logic is64, input logic [63:0] addr);
        bus.trn_rbar_hit_n = bar_n;
        bus.trn_rsrc_rdy_n = 1'b0;
        bus.trn_rsof_n     = 1'b0;
        bus.trn_reof_n     = 1'b1;
        bus.trn_rrem_n     = 8'h00;
        bus.trn_rd = {1'b0, ft, 1'b0, tc, 4'b0, 2'b0, attr, 2'b0, len, rid, tag, 8'h0F};
        @(posedge clk); #1;
        bus.trn_rsof_n = 1'b1;
        bus.trn_reof_n = 1'b0;
        if (is64) begin
            bus.trn_rd     = addr;
            bus.trn_rrem_n = 8'h00;
        end else begin
            bus.trn_rd     = {addr[31:0], 32'h0};
            bus.trn_rrem_n = 8'h0F;
        end
        @(posedge clk); #1;
        rx_idle();
    endtask

    task automatic collect(input bit toggle, output logic [63:0] b0, output logic [63:0] b1,
                           output logic [7:0] r0, output logic [7:0] r1,
                           output logic [1:0] f0, output logic [1:0] f1,
                           output int nbeats, output int first_cyc, output bit ok);
        int cyc;
        bit prev_stall;
        logic [74:0] prev, cur;
        cyc = 0; prev_stall = 0; prev = '0; ok = 0; nbeats = 0; first_cyc = -1;
        b0 = '0; b1 = '0; r0 = '0; r1 = '0; f0 = '0; f1 = '0;
        if (toggle) bus.trn_tdst_rdy_n = 1'b1;
        while (!ok && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (toggle) bus.trn_tdst_rdy_n = ~bus.trn_tdst_rdy_n;
            else        bus.trn_tdst_rdy_n = 1'b0;
            cur = {bus.trn_tsrc_rdy_n, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_trem_n, bus.trn_td};
            if (prev_stall) check("stall_hold", {21'b0, cur}, {21'b0, prev});
            prev_stall = 0;
            if (!bus.trn_tsrc_rdy_n) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (!bus.trn_tdst_rdy_n) begin
                    if (nbeats == 0) begin
                        b0 = bus.trn_td; r0 = bus.trn_trem_n; f0 = {bus.trn_tsof_n, bus.trn_teof_n};
                    end else begin
                        b1 = bus.trn_td; r1 = bus.trn_trem_n; f1 = {bus.trn_tsof_n, bus.trn_teof_n};
                    end
                    nbeats++;
                    if (!bus.trn_teof_n) ok = 1;
                end else begin
                    prev_stall = 1;
                    prev = cur;
                end
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL collect_timeout: got no eof beat expected completion within 200 cycles");
        end else begin
            @(posedge clk); #1;
            check("tx_done_pulse", {94'b0, bus.tx_done, bus.trn_tsrc_rdy_n}, {94'b0, 2'b11});
            @(posedge clk); #1;
            check("tx_done_single", {95'b0, bus.tx_done}, 96'b0);
        end
        bus.trn_tdst_rdy_n = 1'b0;
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_ctrl"}, {89'b0, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n,
              bus.trn_tsrc_dsc_n, bus.tx_req, bus.tx_done, overflow}, {89'b0, 7'b1111000});
        check({name, "_td"},   {32'b0, bus.trn_td}, 96'b0);
        check({name, "_trem"}, {88'b0, bus.trn_trem_n}, {88'b0, 8'hFF});
    endtask

    initial begin
        logic [63:0] b0, b1;
        logic [7:0]  r0, r1;
        logic [1:0]  f0, f1;
        int nb, fc;
        bit ok, saw_req;

        //            is64 addr                    len  tc  attr rid      tag    dw0           dw1           dw2           dw3           rem1
        vecs[0] = '{1'b0, 64'h0000_0000_0000_0040, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h05, 32'h4A000001, 32'h0A080004, 32'h01000540, 32'h88776655, 8'h00};
        vecs[1] = '{1'b1, 64'h0000_0001_0000_0064, 10'd1, 3'd2, 2'd1, 16'h0100, 8'h06, 32'h4A201001, 32'h0A080004, 32'h01000664, 32'h01000000, 8'h00};
        vecs[2] = '{1'b0, 64'h0000_0000_F000_0044, 10'd1, 3'd0, 2'd0, 16'h1234, 8'h07, 32'h4A000001, 32'h0A080004, 32'h12340744, 32'h44332211, 8'h00};
        vecs[3] = '{1'b0, 64'h0000_0000_0000_0048, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h08, 32'h4A000001, 32'h0A080004, 32'h01000848, 32'h1100FFEE, 8'h00};
        vecs[4] = '{1'b1, 64'h0000_0002_0000_004C, 10'd1, 3'd0, 2'd0, 16'hBEEF, 8'hFF, 32'h4A000001, 32'h0A080004, 32'hBEEFFF4C, 32'hDDCCBBAA, 8'h00};
        vecs[5] = '{1'b0, 64'h0000_0000_0000_0060, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h09, 32'h4A000001, 32'h0A080004, 32'h01000960, 32'h00000000, 8'h00};
        vecs[6] = '{1'b0, 64'h0000_0000_0000_0058, 10'd1, 3'd0, 2'd0, 16'h0100, 8'h0A, 32'h4A000001, 32'h0A080004, 32'h01000A58, 32'h00000000, 8'h00};
        vecs[7] = '{1'b0, 64'h0000_0000_0000_0040, 10'd2, 3'd0, 2'd0, 16'h0100, 8'h0B, 32'h0A000000, 32'h0A082004, 32'h01000B40, 32'h00000000, 8'h0F};
        vecs[8] = '{1'b0, 64'h0000_0000_0000_0064, 10'd0, 3'd7, 2'd3, 16'h0200, 8'h0C, 32'h0A703000, 32'h0A082004, 32'h02000C64, 32'h00000000, 8'h0F};

        cpl_id = 16'h0A08;
        hpa1   = 64'h11223344_55667788;
        hpa2   = 64'hAABBCCDD_EEFF0011;
        st1    = 1'b0;
        st2    = 1'b1;
        rx_idle();
        bus.trn_rdst_rdy_n = 1'b0;
        bus.trn_tdst_rdy_n = 1'b0;
        bus.tx_gnt         = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b0;

        // Table vectors: full completion contents and minimum latency.
        for (int i = 0; i < 9; i++) begin
            send_tlp(vecs[i].is64 ? 7'h20 : 7'h00, 7'b1111011, vecs[i].tc, vecs[i].attr,
                     vecs[i].len, vecs[i].rid, vecs[i].tag, vecs[i].is64, vecs[i].addr);
            collect(1'b0, b0, b1, r0, r1, f0, f1, nb, fc, ok);
            check($sformatf("v%0d_dw0", i),   {64'b0, b0[63:32]}, {64'b0, vecs[i].dw0});
            check($sformatf("v%0d_dw1", i),   {64'b0, b0[31:0]},  {64'b0, vecs[i].dw1});
            check($sformatf("v%0d_dw2", i),   {64'b0, b1[63:32]}, {64'b0, vecs[i].dw2});
            check($sformatf("v%0d_dw3", i),   {64'b0, b1[31:0]},  {64'b0, vecs[i].dw3});
            check($sformatf("v%0d_rem", i),   {80'b0, r0, r1},    {80'b0, 8'h00, vecs[i].rem1});
            check($sformatf("v%0d_flags", i), {92'b0, f0, f1},    {92'b0, 2'b01, 2'b10});
            check($sformatf("v%0d_latency", i), 96'(fc + 1), 96'd3);
        end

        // Backpressure toggling every cycle.
        send_tlp(7'h00, 7'b1111011, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h05, 1'b0, 64'h40);
        collect(1'b1, b0, b1, r0, r1, f0, f1, nb, fc, ok);
        check("tog_beats", 96'(nb), 96'd2);
        check("tog_beat0", {32'b0, b0}, {32'b0, 32'h4A000001, 32'h0A080004});
        check("tog_beat1", {32'b0, b1}, {32'b0, 32'h01000540, 32'h88776655});

        // Five reads with no grant: one dropped, four returned in order.
        bus.tx_gnt = 1'b0;
        for (int i = 0; i < 5; i++)
            send_tlp(7'h00, 7'b1111011, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h10 + 8'(i), 1'b0, 64'h40);
        @(posedge clk); #1;
        check("ovf_flag", {93'b0, overflow, bus.tx_req, bus.trn_tsrc_rdy_n}, {93'b0, 3'b111});
        bus.tx_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            collect(1'b0, b0, b1, r0, r1, f0, f1, nb, fc, ok);
            check($sformatf("ovf_order%0d", i), {64'b0, b1[63:32]}, {64'b0, 16'h0100, 8'h10 + 8'(i), 8'h40});
        end
        saw_req = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.tx_req || !bus.trn_tsrc_rdy_n) saw_req = 1'b1;
        end
        check("ovf_no_fifth", {95'b0, saw_req}, 96'b0);

        // Reads outside BAR2 and writes to BAR2 are ignored.
        send_tlp(7'h00, 7'b1111110, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h30, 1'b0, 64'h40);
        send_tlp(7'h40, 7'b1111011, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h31, 1'b0, 64'h40);
        saw_req = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.tx_req) saw_req = 1'b1;
        end
        check("ignore_other", {95'b0, saw_req}, 96'b0);

        // Reset in the middle of beat1 with a second request still queued.
        bus.trn_tdst_rdy_n = 1'b1;
        send_tlp(7'h00, 7'b1111011, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h20, 1'b0, 64'h40);
        send_tlp(7'h00, 7'b1111011, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h21, 1'b0, 64'h40);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (!bus.trn_tsrc_rdy_n) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("rst_beat0_seen", {95'b0, ok}, {95'b0, 1'b1});
        bus.trn_tdst_rdy_n = 1'b0;
        @(posedge clk); #1;
        bus.trn_tdst_rdy_n = 1'b1;
        check("rst_in_beat1", {63'b0, bus.trn_teof_n, bus.trn_td[63:32]}, {63'b0, 1'b0, 32'h01002040});
        #2 rst = 1'b1;
        #1;
        check_reset_outs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        bus.trn_tdst_rdy_n = 1'b0;
        saw_req = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.tx_req) saw_req = 1'b1;
        end
        check("rst_flushed", {95'b0, saw_req}, 96'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
